// File: rtl/rtc_bus_sequencer.sv
// Bus sequencer for the RTC chip's multiplexed address/data bus: periodic register read sweeps
// with user writes slotted in between transactions. Optional macro: RTC_AUTO_REFRESH_EN.
module rtc_bus_sequencer #(
    parameter int         NUM_REGS       = 11,
    parameter logic [7:0] ADDR_BASE      = 8'h21,
    parameter int         T_PHASE        = 8,
    parameter int         REFRESH_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       busy,
    output logic       sweep_done,
    output logic       reg_we,
    output logic [3:0] reg_idx,
    output logic [7:0] reg_data,
    output logic [7:0] ad_out,
    input  logic [7:0] ad_in,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ale
);

    if (T_PHASE < 2 || T_PHASE > 255 || NUM_REGS < 1 || NUM_REGS > 16 || REFRESH_CYCLES < 2)
    begin : g_bad_params
        $error("rtc_bus_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        RECOV = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] phase_q;
    logic [3:0] idx_q;
    logic       sweep_active_q;
    logic       sweep_pending_q;
    logic       is_wr_q;
    logic [7:0] tx_addr_q;
    logic [7:0] tx_wdata_q;

    logic last_phase;
    logic decide;
    logic launch_wr;
    logic launch_rd;
    logic launch_sweep;
    logic capture;
    logic wr_done;
    logic last_idx;
    logic refresh_wrap;

    assign last_phase = (phase_q == 8'(T_PHASE - 1));
    assign decide     = (state_q == IDLE) || ((state_q == RECOV) && last_phase);
    assign capture    = (state_q == DATA) && last_phase && !is_wr_q;
    assign wr_done    = (state_q == DATA) && last_phase && is_wr_q;
    assign last_idx   = (idx_q == 4'(NUM_REGS - 1));

`ifdef RTC_AUTO_REFRESH_EN
    localparam int RW = $clog2(REFRESH_CYCLES);
    logic [RW-1:0] refresh_q;

    assign refresh_wrap = (refresh_q == RW'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
        end else if (refresh_wrap) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end
`else
    assign refresh_wrap = 1'b0;
`endif

    // Next state; transactions are only launched at a decision point so a write never splits a read.
    always_comb begin
        state_d      = state_q;
        launch_wr    = 1'b0;
        launch_rd    = 1'b0;
        launch_sweep = 1'b0;
        case (state_q)
            IDLE:    state_d = IDLE;
            ADDR:    if (last_phase) state_d = DATA;
            DATA:    if (last_phase) state_d = RECOV;
            RECOV:   if (last_phase) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (decide) begin
            if (wr_req) begin
                launch_wr = 1'b1;
                state_d   = ADDR;
            end else if (sweep_active_q) begin
                launch_rd = 1'b1;
                state_d   = ADDR;
            end else if (sweep_pending_q || start) begin
                launch_sweep = 1'b1;
                state_d      = ADDR;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            if ((state_d != state_q) || (state_q == IDLE)) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + 1'b1;
            end
        end
    end

    // Transaction latch, sweep bookkeeping and the capture/ack strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_wr_q         <= 1'b0;
            tx_addr_q       <= '0;
            tx_wdata_q      <= '0;
            idx_q           <= '0;
            sweep_active_q  <= 1'b0;
            sweep_pending_q <= 1'b0;
            reg_we          <= 1'b0;
            reg_idx         <= '0;
            reg_data        <= '0;
            sweep_done      <= 1'b0;
            wr_ack          <= 1'b0;
        end else begin
            if (launch_wr) begin
                is_wr_q    <= 1'b1;
                tx_addr_q  <= wr_addr;
                tx_wdata_q <= wr_data;
            end else if (launch_rd) begin
                is_wr_q   <= 1'b0;
                tx_addr_q <= ADDR_BASE + {4'b0000, idx_q};
            end else if (launch_sweep) begin
                is_wr_q        <= 1'b0;
                tx_addr_q      <= ADDR_BASE;
                idx_q          <= '0;
                sweep_active_q <= 1'b1;
            end

            // A start or refresh while a sweep is running or queued collapses into one pending sweep.
            if (launch_sweep) begin
                sweep_pending_q <= 1'b0;
            end else begin
                sweep_pending_q <= sweep_pending_q | start | refresh_wrap;
            end

            reg_we     <= capture;
            sweep_done <= capture && last_idx;
            wr_ack     <= wr_done;
            if (capture) begin
                reg_idx  <= idx_q;
                reg_data <= ad_in;
                if (last_idx) begin
                    idx_q          <= '0;
                    sweep_active_q <= 1'b0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    // Bus pins decode from the registered state so reset releases them at once.
    always_comb begin
        cs_n   = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        ale    = 1'b0;
        ad_oe  = 1'b0;
        ad_out = 8'h00;
        case (state_q)
            ADDR: begin
                cs_n   = 1'b0;
                ale    = 1'b1;
                wr_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = tx_addr_q;
            end
            DATA: begin
                cs_n = 1'b0;
                if (is_wr_q) begin
                    wr_n   = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = tx_wdata_q;
                end else begin
                    rd_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule
